// File: rtl/scam_pkg.sv
// Shared phase constants and depth-clip helper for the SCA block-sequence controller.
// No logic state; no latency or backpressure of its own.
package scam_pkg;

  localparam int PH_SELC    = 2;
  localparam int PH_SELB    = 3;
  localparam int PH_SELD    = 4;
  localparam int PH_SELA    = 5;
  localparam int PH_PRE_OFF = 3;
  localparam int PH_NB_OFF  = 2;
  localparam int PH_ENA_OFF = 1;

  // Requested match depth clipped to 1..depth, so a zero request still looks at hist[0].
  function automatic int clip_depth(input int md, input int depth);
    if (md < 1) return 1;
    if (md > depth) return depth;
    return md;
  endfunction

endpackage

// File: rtl/cbnce.sv
// Width-bit up counter with clock enable and synchronous clear, optional triplicated state.
// Q updates one clock after CE/CLR; no backpressure.
module cbnce #(
  parameter int Width = 4,
  parameter int TMR   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             CLR,
  output logic [Width-1:0] Q
);

  generate
    if (TMR != 0) begin : g_tmr
      logic [Width-1:0] q_a, q_b, q_c, voted;
      assign voted = (q_a & q_b) | (q_a & q_c) | (q_b & q_c);
      // All three copies reload from the vote so a single upset is scrubbed next cycle.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          q_a <= '0;
          q_b <= '0;
          q_c <= '0;
        end else if (CLR) begin
          q_a <= '0;
          q_b <= '0;
          q_c <= '0;
        end else if (CE) begin
          q_a <= voted + 1'b1;
          q_b <= voted + 1'b1;
          q_c <= voted + 1'b1;
        end else begin
          q_a <= voted;
          q_b <= voted;
          q_c <= voted;
        end
      end
      assign Q = voted;
    end else begin : g_plain
      logic [Width-1:0] q_r;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)       q_r <= '0;
        else if (CLR)  q_r <= '0;
        else if (CE)   q_r <= q_r + 1'b1;
      end
      assign Q = q_r;
    end
  endgenerate

endmodule

// File: rtl/scam_lct_hist.sv
// Per-block LCT flag (or saturating counter with SCAM_LCT_CNT_EN), block history and depth-ORed llct.
// History shifts on preblkend, llct valid the cycle after; no backpressure.
module scam_lct_hist
  import scam_pkg::*;
#(
  parameter int HIST_DEPTH = 3,
  parameter int CNT_W      = 4,
  parameter int MD_W       = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             resync,
  input  logic             lctdly,
  input  logic             preblkend,
  input  logic [MD_W-1:0]  match_depth,
  output logic             llct
`ifdef SCAM_LCT_CNT_EN
  ,
  output logic [CNT_W-1:0] lctcnt,
  output logic             lct_ovf
`endif
);

  logic                  lctsave;
  logic [HIST_DEPTH-1:0] hist;

`ifdef SCAM_LCT_CNT_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign cnt_next = (lctdly && cnt != '1) ? cnt + 1'b1 : cnt;
  assign lctsave  = (cnt != '0) | lctdly;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      lctcnt  <= '0;
      lct_ovf <= 1'b0;
    end else if (resync) begin
      cnt     <= '0;
      lctcnt  <= '0;
      lct_ovf <= 1'b0;
    end else if (preblkend) begin
      cnt     <= '0;
      lctcnt  <= cnt_next;
      lct_ovf <= (cnt_next == '1);
    end else begin
      cnt     <= cnt_next;
      lct_ovf <= 1'b0;
    end
  end
`else
  logic flag;

  assign lctsave = flag | lctdly;

  // Clear beats set: an LCT on the closing cycle is captured via lctsave instead.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      flag <= 1'b0;
    else if (resync || preblkend) flag <= 1'b0;
    else if (lctdly)              flag <= 1'b1;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hist <= '0;
    end else if (resync) begin
      hist <= '0;
    end else if (preblkend) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= lctsave;
    end
  end

  always_comb begin
    int d;
    d    = clip_depth(int'(match_depth), HIST_DEPTH);
    llct = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (i < d) llct = llct | hist[i];
    end
  end

endmodule

// File: rtl/scam_seq_ctrl.sv
// SCA block-sequence controller: phase counter plus combinational write-select strobes; SCAM_LCT_CNT_EN adds LCTCNT/LCT_OVF.
// Strobes decode same-cycle from STATE; LCTYENA/NOLCT follow history one cycle after PREBLKEND; no backpressure.
module scam_seq_ctrl
  import scam_pkg::*;
#(
  parameter int PHASE_W    = 4,
  parameter int HIST_DEPTH = 3,
  parameter int CNT_W      = 4,
  parameter int TMR        = 0
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            RESYNC,
  input  logic                            LCTDLY,
  input  logic                            DONE,
  input  logic                            NOL1A_MATCH,
  input  logic                            NODATA,
  input  logic                            FB_NODATA,
  input  logic                            SCND_BLK,
  input  logic                            SCND_SHARED,
  input  logic                            DLSCAFULL,
  input  logic                            DSCAFULL,
  input  logic                            MTCH_3BX,
  input  logic [$clog2(HIST_DEPTH+1)-1:0] MATCH_DEPTH,
  output logic [PHASE_W-1:0]              STATE,
  output logic                            SELA,
  output logic                            SELB,
  output logic                            SELC,
  output logic                            SELD,
  output logic                            WRENA,
  output logic                            ENAREG,
  output logic                            PREBLKEND,
  output logic                            NBSEL,
  output logic                            LCTYENA,
  output logic                            NOLCT
`ifdef SCAM_LCT_CNT_EN
  ,
  output logic [CNT_W-1:0]                LCTCNT,
  output logic                            LCT_OVF
`endif
);

  localparam int N    = 1 << PHASE_W;
  localparam int MD_W = $clog2(HIST_DEPTH + 1);

  localparam logic [PHASE_W-1:0] P_SELA = PHASE_W'(PH_SELA);
  localparam logic [PHASE_W-1:0] P_SELB = PHASE_W'(PH_SELB);
  localparam logic [PHASE_W-1:0] P_SELC = PHASE_W'(PH_SELC);
  localparam logic [PHASE_W-1:0] P_SELD = PHASE_W'(PH_SELD);
  localparam logic [PHASE_W-1:0] P_ENA  = PHASE_W'(N - PH_ENA_OFF);
  localparam logic [PHASE_W-1:0] P_NB   = PHASE_W'(N - PH_NB_OFF);
  localparam logic [PHASE_W-1:0] P_PRE  = PHASE_W'(N - PH_PRE_OFF);

  logic llct;
  logic selc_qual;

  // Free-running phase; natural PHASE_W-bit rollover provides the N-1 -> 0 wrap.
  cbnce #(.Width(PHASE_W), .TMR(TMR)) u_phase (
    .CLK (CLK),
    .RST (RST),
    .CE  (1'b1),
    .CLR (RESYNC),
    .Q   (STATE)
  );

  assign selc_qual = MTCH_3BX ? (SCND_BLK & ~SCND_SHARED) : 1'b1;

  assign SELA      = (STATE == P_SELA);
  assign SELB      = (STATE == P_SELB) & NOL1A_MATCH & ~DLSCAFULL;
  assign SELC      = (STATE == P_SELC) & DONE & ~NODATA & selc_qual;
  assign SELD      = (STATE == P_SELD) & MTCH_3BX & DONE & SCND_BLK & ~FB_NODATA;
  assign ENAREG    = (STATE == P_ENA);
  assign NBSEL     = (STATE == P_NB);
  assign PREBLKEND = (STATE == P_PRE);
  assign LCTYENA   = NBSEL & llct;
  assign NOLCT     = NBSEL & ~llct & ~DSCAFULL;
  assign WRENA     = SELA | SELB | SELC | SELD | NOLCT;

  scam_lct_hist #(.HIST_DEPTH(HIST_DEPTH), .CNT_W(CNT_W), .MD_W(MD_W)) u_hist (
    .CLK         (CLK),
    .RST         (RST),
    .resync      (RESYNC),
    .lctdly      (LCTDLY),
    .preblkend   (PREBLKEND),
    .match_depth (MATCH_DEPTH),
    .llct        (llct)
`ifdef SCAM_LCT_CNT_EN
    ,
    .lctcnt      (LCTCNT),
    .lct_ovf     (LCT_OVF)
`endif
  );

endmodule

// File: tb/tb_scam_seq_ctrl.sv
// Randomized bench for scam_seq_ctrl against a block-level reference model (SCAM_LCT_CNT_EN aware).
// Inputs driven on the falling edge, outputs compared 1ns later, model advanced on the rising edge.
module tb_scam_seq_ctrl;

  localparam int PHASE_W    = 4;
  localparam int HIST_DEPTH = 3;
  localparam int CNT_W      = 4;
  localparam int N          = 1 << PHASE_W;
  localparam int MD_W       = $clog2(HIST_DEPTH + 1);
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST;
  logic RESYNC, LCTDLY, DONE, NOL1A_MATCH, NODATA, FB_NODATA;
  logic SCND_BLK, SCND_SHARED, DLSCAFULL, DSCAFULL, MTCH_3BX;
  logic [MD_W-1:0] MATCH_DEPTH;
  logic [PHASE_W-1:0] STATE;
  logic SELA, SELB, SELC, SELD, WRENA, ENAREG, PREBLKEND, NBSEL, LCTYENA, NOLCT;
`ifdef SCAM_LCT_CNT_EN
  logic [CNT_W-1:0] LCTCNT;
  logic             LCT_OVF;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: block phase, "any LCT this block", per-block history (newest first)
  int m_phase;
  bit m_cur;
  bit m_hist[$];
  int m_cnt;
  int m_lctcnt;
  bit m_ovf;

  always #5 CLK = ~CLK;

  scam_seq_ctrl #(.PHASE_W(PHASE_W), .HIST_DEPTH(HIST_DEPTH), .CNT_W(CNT_W), .TMR(0)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RESYNC      (RESYNC),
    .LCTDLY      (LCTDLY),
    .DONE        (DONE),
    .NOL1A_MATCH (NOL1A_MATCH),
    .NODATA      (NODATA),
    .FB_NODATA   (FB_NODATA),
    .SCND_BLK    (SCND_BLK),
    .SCND_SHARED (SCND_SHARED),
    .DLSCAFULL   (DLSCAFULL),
    .DSCAFULL    (DSCAFULL),
    .MTCH_3BX    (MTCH_3BX),
    .MATCH_DEPTH (MATCH_DEPTH),
    .STATE       (STATE),
    .SELA        (SELA),
    .SELB        (SELB),
    .SELC        (SELC),
    .SELD        (SELD),
    .WRENA       (WRENA),
    .ENAREG      (ENAREG),
    .PREBLKEND   (PREBLKEND),
    .NBSEL       (NBSEL),
    .LCTYENA     (LCTYENA),
    .NOLCT       (NOLCT)
`ifdef SCAM_LCT_CNT_EN
    ,
    .LCTCNT      (LCTCNT),
    .LCT_OVF     (LCT_OVF)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [9:0] dut_strobes();
    return {SELA, SELB, SELC, SELD, WRENA, ENAREG, PREBLKEND, NBSEL, LCTYENA, NOLCT};
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_cur    = 0;
    m_cnt    = 0;
    m_lctcnt = 0;
    m_ovf    = 0;
    m_hist.delete();
    for (int i = 0; i < HIST_DEPTH; i++) m_hist.push_back(1'b0);
  endtask

  function automatic logic [9:0] model_strobes();
    bit sela, selb, selc, seld, ena, nb, pre, llct, lyena, nolct, wr;
    int d;
    sela = (m_phase == 5);
    selb = (m_phase == 3) && NOL1A_MATCH && !DLSCAFULL;
    selc = (m_phase == 2) && DONE && !NODATA && (!MTCH_3BX || (SCND_BLK && !SCND_SHARED));
    seld = (m_phase == 4) && MTCH_3BX && DONE && SCND_BLK && !FB_NODATA;
    ena  = (m_phase == N - 1);
    nb   = (m_phase == N - 2);
    pre  = (m_phase == N - 3);
    d    = (MATCH_DEPTH == 0) ? 1 : ((int'(MATCH_DEPTH) > HIST_DEPTH) ? HIST_DEPTH : int'(MATCH_DEPTH));
    llct = 0;
    for (int i = 0; i < d; i++) llct = llct | m_hist[i];
    lyena = nb && llct;
    nolct = nb && !llct && !DSCAFULL;
    wr    = sela | selb | selc | seld | nolct;
    return {sela, selb, selc, seld, wr, ena, pre, nb, lyena, nolct};
  endfunction

  task automatic model_step();
    int v;
    if (RESYNC) begin
      model_reset();
      return;
    end
    v = (m_cnt + int'(LCTDLY) > CMAX) ? CMAX : m_cnt + int'(LCTDLY);
    if (m_phase == N - 3) begin
      m_hist.push_front(m_cur | LCTDLY);
      void'(m_hist.pop_back());
      m_cur    = 0;
      m_lctcnt = v;
      m_ovf    = (v == CMAX);
      m_cnt    = 0;
    end else begin
      m_cur = m_cur | LCTDLY;
      m_cnt = v;
      m_ovf = 0;
    end
    m_phase = (m_phase + 1) % N;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_state"}, 32'(STATE), 32'(m_phase));
    chk({tag, "_strobes"}, 32'(dut_strobes()), 32'(model_strobes()));
`ifdef SCAM_LCT_CNT_EN
    chk({tag, "_lctcnt"}, 32'(LCTCNT), 32'(m_lctcnt));
    chk({tag, "_ovf"}, 32'(LCT_OVF), 32'(m_ovf));
`endif
  endtask

  task automatic zero_inputs();
    {RESYNC, LCTDLY, DONE, NOL1A_MATCH, NODATA, FB_NODATA} = '0;
    {SCND_BLK, SCND_SHARED, DLSCAFULL, DSCAFULL, MTCH_3BX} = '0;
    MATCH_DEPTH = '0;
  endtask

  initial begin
    bit dense;
    RST = 1'b1;
    zero_inputs();
    dense = 0;
    model_reset();
    repeat (3) @(negedge CLK);
    #1;
    check_all("reset");
    @(negedge CLK);
    RST = 1'b0;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc % 400 == 0) begin
        MATCH_DEPTH = MD_W'($urandom_range(0, (1 << MD_W) - 1));
        MTCH_3BX    = 1'($urandom_range(0, 1));
        dense       = ((cyc / 400) % 4 == 3);
      end
      if (cyc == 3000) begin
        RST = 1'b1;
        #1;
        chk("midrst_state", 32'(STATE), 32'd0);
        chk("midrst_strobes", 32'(dut_strobes()), 32'd0);
        @(negedge CLK);
        chk("midrst_hold", 32'(STATE), 32'd0);
        RST = 1'b0;
        model_reset();
      end
      RESYNC      = ($urandom_range(0, 199) == 0);
      LCTDLY      = dense ? 1'b1 : ($urandom_range(0, 24) == 0);
      DONE        = 1'($urandom_range(0, 1));
      NOL1A_MATCH = 1'($urandom_range(0, 1));
      NODATA      = ($urandom_range(0, 3) == 0);
      FB_NODATA   = ($urandom_range(0, 3) == 0);
      SCND_BLK    = 1'($urandom_range(0, 1));
      SCND_SHARED = ($urandom_range(0, 3) == 0);
      DLSCAFULL   = ($urandom_range(0, 3) == 0);
      DSCAFULL    = ($urandom_range(0, 3) == 0);
      #1;
      check_all("run");
      @(posedge CLK);
      model_step();
      @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
